// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word RAM between instruction fetch and data load/store.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates the grant on ties instead of always favouring data.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int STRB_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_enable,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_resp_valid,
  input  logic                  if_resp_ready,
  output logic [8*STRB_W-1:0]   if_resp_rdata,
  output logic [1:0]            if_resp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [8*STRB_W-1:0]   d_req_wdata,
  input  logic [STRB_W-1:0]     d_req_strb,
  output logic                  d_resp_valid,
  input  logic                  d_resp_ready,
  output logic [8*STRB_W-1:0]   d_resp_rdata,
  output logic [1:0]            d_resp_err,
  output logic                  mem_r_en,
  output logic [ADDR_W-1:0]     mem_r_addr,
  input  logic [8*STRB_W-1:0]   mem_r_data,
  output logic                  mem_w_en,
  output logic [ADDR_W-1:0]     mem_w_addr,
  output logic [8*STRB_W-1:0]   mem_w_data,
  output logic [STRB_W-1:0]     mem_w_strb,
  input  logic [1:0]            mem_state,
  output logic                  busy
);

  localparam int   DATA_W      = 8 * STRB_W;
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } state_e;

  state_e              state_r;
  logic                owner_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [STRB_W-1:0]   strb_r;
  logic [1:0]          err_r;
  logic                if_resp_valid_r;
  logic                d_resp_valid_r;
  logic                mem_r_en_r;
  logic                mem_w_en_r;
  logic                busy_r;

  logic                grant_data_s;
  logic                ready_base_s;
  logic                hs_s;
  logic                resp_ack_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic                sel_we_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [STRB_W-1:0]   sel_strb_s;

  // Grant selection, request mux and response acknowledge decode
  always_comb begin
    grant_data_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // owner_r still holds the previous transaction's owner while in IDLE
    if (d_req_valid && if_req_valid) begin
      grant_data_s = (owner_r == OWNER_FETCH);
    end else begin
      grant_data_s = d_req_valid;
    end
`else
    grant_data_s = d_req_valid;
`endif
    ready_base_s = rst_n && clk_enable && (state_r == IDLE);
    if (grant_data_s) begin
      sel_addr_s  = d_req_addr;
      sel_we_s    = d_req_we;
      sel_wdata_s = d_req_wdata;
      sel_strb_s  = d_req_strb;
      hs_s        = ready_base_s && d_req_valid;
    end else begin
      sel_addr_s  = if_req_addr;
      sel_we_s    = 1'b0;
      sel_wdata_s = {DATA_W{1'b0}};
      sel_strb_s  = {STRB_W{1'b0}};
      hs_s        = ready_base_s && if_req_valid;
    end
    if (owner_r == OWNER_DATA) begin
      resp_ack_s = d_resp_valid_r && d_resp_ready;
    end else begin
      resp_ack_s = if_resp_valid_r && if_resp_ready;
    end
  end

  // Transaction FSM with all outputs registered; clk_enable low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      owner_r         <= OWNER_FETCH;
      we_r            <= 1'b0;
      addr_r          <= {ADDR_W{1'b0}};
      wdata_r         <= {DATA_W{1'b0}};
      rdata_r         <= {DATA_W{1'b0}};
      strb_r          <= {STRB_W{1'b0}};
      err_r           <= 2'b00;
      if_resp_valid_r <= 1'b0;
      d_resp_valid_r  <= 1'b0;
      mem_r_en_r      <= 1'b0;
      mem_w_en_r      <= 1'b0;
      busy_r          <= 1'b0;
    end else if (clk_enable) begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            owner_r <= grant_data_s;
            we_r    <= sel_we_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
            strb_r  <= sel_strb_s;
            rdata_r <= {DATA_W{1'b0}};
            busy_r  <= 1'b1;
            // Misaligned requests are answered without touching the RAM
            if (sel_addr_s[1:0] != 2'b00) begin
              err_r           <= 2'b11;
              if_resp_valid_r <= ~grant_data_s;
              d_resp_valid_r  <= grant_data_s;
              state_r         <= RESP;
            end else begin
              err_r      <= 2'b00;
              mem_r_en_r <= ~sel_we_s;
              mem_w_en_r <= sel_we_s;
              state_r    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_r_en_r <= 1'b0;
          mem_w_en_r <= 1'b0;
          state_r    <= CAPTURE;
        end
        CAPTURE: begin
          err_r <= mem_state;
          if (!we_r && (mem_state == 2'b00)) begin
            rdata_r <= mem_r_data;
          end else begin
            rdata_r <= {DATA_W{1'b0}};
          end
          if_resp_valid_r <= (owner_r == OWNER_FETCH);
          d_resp_valid_r  <= (owner_r == OWNER_DATA);
          state_r         <= RESP;
        end
        RESP: begin
          if (resp_ack_s) begin
            if_resp_valid_r <= 1'b0;
            d_resp_valid_r  <= 1'b0;
            busy_r          <= 1'b0;
            state_r         <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign if_req_ready  = ready_base_s && !grant_data_s;
  assign d_req_ready   = ready_base_s && grant_data_s;
  assign if_resp_valid = if_resp_valid_r;
  assign d_resp_valid  = d_resp_valid_r;
  assign if_resp_rdata = rdata_r;
  assign d_resp_rdata  = rdata_r;
  assign if_resp_err   = err_r;
  assign d_resp_err    = err_r;
  assign mem_r_en      = mem_r_en_r;
  assign mem_r_addr    = addr_r;
  assign mem_w_en      = mem_w_en_r;
  assign mem_w_addr    = addr_r;
  assign mem_w_data    = wdata_r;
  assign mem_w_strb    = strb_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: RAM model plus a word-array reference of expected responses.
module tb_mem_port_arbiter;

  localparam int RAM_WORDS = 64;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_enable = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_req_addr = 32'd0;
  logic        if_resp_valid;
  logic        if_resp_ready = 1'b0;
  logic [31:0] if_resp_rdata;
  logic [1:0]  if_resp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_addr = 32'd0;
  logic [31:0] d_req_wdata = 32'd0;
  logic [3:0]  d_req_strb = 4'd0;
  logic        d_resp_valid;
  logic        d_resp_ready = 1'b0;
  logic [31:0] d_resp_rdata;
  logic [1:0]  d_resp_err;
  logic        mem_r_en;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_w_strb;
  logic [1:0]  mem_state;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_mem [RAM_WORDS];
  bit last_owner_m = 1'b0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_resp_rdata(if_resp_rdata), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_strb(d_req_strb),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_strb(mem_w_strb), .mem_state(mem_state), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = i;
    if (i == 4) return 32'hDEADBEEF;
    return (v * 32'h9E3779B9) ^ 32'h00C0FFEE;
  endfunction

  // RAM environment: 64 words, registered read data and status, out-of-range flagged as 2'b10
  logic [31:0] ram [RAM_WORDS];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_r_en && mem_w_en) begin
      mem_state <= 2'b01;
    end else if (mem_r_en) begin
      if (mem_r_addr[31:8] == 24'd0) begin
        mem_r_data <= ram[mem_r_addr[7:2]];
        mem_state  <= 2'b00;
      end else begin
        mem_r_data <= 32'hBAD0BAD0;
        mem_state  <= 2'b10;
      end
    end else if (mem_w_en) begin
      if (mem_w_addr[31:8] == 24'd0) begin
        for (int b = 0; b < 4; b++)
          if (mem_w_strb[b]) ram[mem_w_addr[7:2]][8*b +: 8] <= mem_w_data[8*b +: 8];
        mem_state <= 2'b00;
      end else begin
        mem_state <= 2'b10;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the requester should see, computed from the access rules on a word array
  task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic [1:0] err);
    int idx;
    rdata = 32'd0;
    if (addr % 4 != 0) begin
      err = 2'b11;
    end else if (addr >= RAM_WORDS * 4) begin
      err = 2'b10;
    end else begin
      err = 2'b00;
      idx = addr / 4;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rdata = ref_mem[idx];
      end
    end
  endtask

  task automatic do_op(input bit is_data, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input int resp_delay, input int freeze);
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    bit aligned, is_store, exp_r_en, exp_w_en;
    logic [31:0] held;
    int n;
    aligned  = (addr[1:0] == 2'b00);
    is_store = is_data && we;
    exp_r_en = aligned && !is_store;
    exp_w_en = aligned && is_store;
    model(is_store, addr, wdata, strb, exp_rdata, exp_err);
    if (is_data) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata; d_req_strb = strb;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    #1;
    n = 0;
    while (!(is_data ? d_req_ready : if_req_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready", is_data ? d_req_ready : if_req_ready, 1'b1);
    @(posedge clk); #1;
    last_owner_m = is_data;
    if (is_data) d_req_valid = 1'b0; else if_req_valid = 1'b0;
    check("mem_r_en", mem_r_en, exp_r_en);
    check("mem_w_en", mem_w_en, exp_w_en);
    if (exp_r_en) check("mem_r_addr", mem_r_addr, addr);
    if (exp_w_en) check("mem_w_addr_strb_data", {mem_w_addr, mem_w_strb, mem_w_data}, {addr, strb, wdata});
    n = 0;
    while (!(is_data ? d_resp_valid : if_resp_valid) && n < 20) begin
      @(posedge clk); #1; n++;
      if (n == 1) check("mem_en_one_cycle", {mem_r_en, mem_w_en}, 2'b00);
    end
    check("resp_latency", n, aligned ? 2 : 0);
    check("resp_rdata", is_data ? d_resp_rdata : if_resp_rdata, exp_rdata);
    check("resp_err", is_data ? d_resp_err : if_resp_err, exp_err);
    check("other_resp_valid", is_data ? if_resp_valid : d_resp_valid, 1'b0);
    check("busy_in_resp", busy, 1'b1);
    held = is_data ? d_resp_rdata : if_resp_rdata;
    repeat (resp_delay) begin @(posedge clk); #1; end
    if (resp_delay > 0) check("resp_hold", is_data ? d_resp_valid : if_resp_valid, 1'b1);
    if (freeze > 0) begin
      clk_enable = 1'b0;
      if (is_data) d_resp_ready = 1'b1; else if_resp_ready = 1'b1;
      repeat (freeze) begin @(posedge clk); #1; end
      check("freeze_valid_busy", {is_data ? d_resp_valid : if_resp_valid, busy}, 2'b11);
      check("freeze_rdata", is_data ? d_resp_rdata : if_resp_rdata, held);
      clk_enable = 1'b1;
    end
    if (is_data) d_resp_ready = 1'b1; else if_resp_ready = 1'b1;
    @(posedge clk); #1;
    d_resp_ready = 1'b0; if_resp_ready = 1'b0;
    check("resp_done", {if_resp_valid, d_resp_valid, busy}, 3'b000);
  endtask

  task automatic tie_pair(input bit d_we, input logic [31:0] d_addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] f_addr);
    bit win_data, win_fetch;
    win_data  = RR ? (last_owner_m == 1'b0) : 1'b1;
    win_fetch = !win_data;
    if_req_valid = 1'b1; if_req_addr = f_addr;
    d_req_valid = 1'b1; d_req_we = d_we; d_req_addr = d_addr; d_req_wdata = wdata; d_req_strb = strb;
    #1;
    check("tie_d_ready", d_req_ready, win_data);
    check("tie_if_ready", if_req_ready, win_fetch);
    if (win_data) begin
      do_op(1'b1, d_we, d_addr, wdata, strb, 0, 0);
      do_op(1'b0, 1'b0, f_addr, 32'd0, 4'd0, 0, 0);
    end else begin
      do_op(1'b0, 1'b0, f_addr, 32'd0, 4'd0, 0, 0);
      do_op(1'b1, d_we, d_addr, wdata, strb, 0, 0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7) return $urandom_range(0, RAM_WORDS - 1) * 4;
    if (sel == 7) return $urandom_range(0, RAM_WORDS - 1) * 4 + $urandom_range(1, 3);
    if (sel == 8) return 32'h100 + $urandom_range(0, 1000) * 4;
    return ($urandom | 32'h80000000) & 32'hFFFFFFFC;
  endfunction

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = init_word(i);
    clk_enable = 1'b1;
    if_req_valid = 1'b1;
    d_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {if_req_ready, if_resp_valid, d_req_ready, d_resp_valid,
                         mem_r_en, mem_w_en, busy, if_resp_err, d_resp_err}, 11'd0);
    check("reset_data", |{if_resp_rdata, d_resp_rdata, mem_r_addr, mem_w_addr, mem_w_data, mem_w_strb}, 1'b0);
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    clk_enable = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr = 32'h10;
    #1;
    check("frozen_idle_ready", if_req_ready, 1'b0);
    clk_enable = 1'b1;
    #1;
    check("idle_ready", if_req_ready, 1'b1);
    if_req_valid = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 1'b0, 32'h10, 32'd0, 4'd0, 0, 0);
    do_op(1'b1, 1'b1, 32'h8, 32'h11223344, 4'b0101, 0, 0);
    do_op(1'b1, 1'b0, 32'h8, 32'd0, 4'd0, 1, 0);
    tie_pair(1'b0, 32'h20, 32'd0, 4'd0, 32'h24);
    tie_pair(1'b1, 32'h28, 32'hCAFEF00D, 4'b1111, 32'h28);
    do_op(1'b1, 1'b0, 32'h6, 32'd0, 4'd0, 0, 0);
    do_op(1'b1, 1'b0, 32'h400, 32'd0, 4'd0, 0, 0);
    do_op(1'b1, 1'b1, 32'hC, 32'hFFFFFFFF, 4'b0000, 0, 0);
    do_op(1'b1, 1'b0, 32'hC, 32'd0, 4'd0, 0, 5);

    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h8;
    #1;
    check("rst_op_ready", d_req_ready, 1'b1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(posedge clk); #1;
    check("capture_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midop_reset_ctrl", {if_req_ready, if_resp_valid, d_req_ready, d_resp_valid,
                               mem_r_en, mem_w_en, busy, if_resp_err, d_resp_err}, 11'd0);
    check("midop_reset_data", |{if_resp_rdata, d_resp_rdata, mem_r_addr, mem_w_addr, mem_w_data, mem_w_strb}, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_owner_m = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 1'b0, 32'h10, 32'd0, 4'd0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0)
        tie_pair(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)), rand_addr());
      else
        do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
